ps2_kbd_evq: RTL and testbench
==============================

Name: ps2_kbd_evq

Overview:
- Parametrised successor of the keyboard front end.
- Receives PS/2 frames and checks start, stop and odd parity, with a watchdog on partial frames.
- Decodes E0 (extended) and F0 (break) prefixes and tracks shift and caps-lock state.
- Queues complete key events in a first-word-fall-through FIFO with a valid/ready pop handshake. Downstream ASCII or CPU logic consumes the events.

Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 events (range 1..6).
- SYNC_STAGES, 2, synchroniser flops on ps2_clk and ps2_data (>=2).
- TIMEOUT, 50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock (CLOCK_50 domain), all logic on rising edge
- clrn  in  1  synchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_data  in  1  raw PS/2 data, asynchronous
- evt_code  out  8  scancode of head event
- evt_break  out  1  head event is a key release
- evt_ext  out  1  head event was E0-prefixed
- evt_shift  out  1  shift state after this event
- evt_caps  out  1  caps-lock state after this event
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer pops head when evt_valid & evt_ready
- count  out  DEPTH_LOG2+1  FIFO occupancy
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- parity_err  out  1  one-cycle pulse: frame discarded on parity
- frame_err  out  1  one-cycle pulse: bad start/stop bit or timeout

Behaviour:
- Reset:
  - clrn=0 at a rising edge clears all state: FIFO empty, count=0, all evt_* outputs 0, overflow/parity_err/frame_err 0.
  - Bit counter 0, decoder IDLE, shift/caps/held flags 0.
  - Reset mid-frame discards the partial frame.
- Synchronisation: ps2_clk and ps2_data each pass through SYNC_STAGES flops. A falling edge is previous synced clk=1 and current=0, and lasts one cycle.
- Receiver:
  - On each falling edge, sample synced data into an 11-bit shift register and increment the bit counter 0..10.
  - Frame order: start(0), D0..D7 LSB first, parity, stop(1).
  - Completion at bit 10:
    - start=0, stop=1 and XOR(D,parity)=1 -> byte_valid pulse the next cycle.
    - Parity wrong only -> parity_err pulse.
    - Start or stop wrong -> frame_err pulse; frame_err takes precedence if both are wrong.
  - The counter returns to 0 on completion.
  - Watchdog: counter!=0 and TIMEOUT cycles with no falling edge -> counter=0, frame_err pulse, no byte.
- Decoder FSM, states IDLE, E0, F0, E0F0, acting on byte_valid:
  - IDLE: E0->E0; F0->F0; other->emit.
  - E0: F0->E0F0; E0 stays E0; other->emit ext=1.
  - F0: other->emit brk=1; a repeated F0 stays in F0.
  - E0F0: other->emit ext=1 brk=1.
  - Every emit returns to IDLE.
- Modifiers (non-extended codes only):
  - lshift=0x12 and rshift=0x59: held flag set on make, cleared on break; shift = lheld|rheld.
  - Caps 0x58: a make with caps_held=0 toggles caps and sets caps_held; a break clears caps_held. Typematic repeats do not toggle.
  - Modifier keys are also emitted as events, with shift/caps already updated.
- Latency: byte_valid in cycle N+1 after the completing edge in cycle N; FIFO write at the end of N+1; evt_valid high in N+2.
- FIFO:
  - Word = {ext,brk,shift,caps,code}, 12 bits, circular pointers wrap at depth.
  - Push when count==depth and no pop that cycle -> event dropped, overflow=1. overflow clears only on reset.
  - Simultaneous push and pop when full: both occur, count unchanged, no overflow.
  - Push while empty: evt_valid rises the next cycle; evt_ready while empty is ignored.
  - Outputs show the head entry; the next entry appears the cycle after a pop.

Test Plan:
- Frame start0, 0x1C (bits 0,0,1,1,1,0,0,0), parity0, stop1, evt_ready=0 -> evt_valid=1, evt_code=0x1C, brk=0, ext=0, shift=0, caps=0, count=1.
- Frames F0,1C then E0,F0,75 -> exactly two events: {0x1C,brk=1,ext=0} then {0x75,brk=1,ext=1}; no events for prefixes.
- Frames 12,1C,F0,12,1C -> events 0x12 shift=1, 0x1C shift=1, 0x12 brk shift=0, 0x1C shift=0.
- Frames 58,58,F0,58,58 -> caps=1,1,1,0; the second 58 (repeat) does not toggle.
- Frame 0x1C with parity bit=1 -> parity_err high exactly one cycle, count stays 0. Frame with stop=0 -> frame_err pulse only.
- DEPTH_LOG2=2, six events, evt_ready=0 -> count=4, overflow=1, first four popped in order. A 5-bit partial frame then TIMEOUT idle cycles -> frame_err pulse; the following good frame 0x1C decodes normally.

Source files
------------

// File: rtl/ps2_kbd_evq.sv
// PS/2 keyboard front end: synchronised frame receiver with watchdog, E0/F0 prefix
// decoder with shift/caps tracking, and a first-word-fall-through event FIFO.
//
// state   | meaning
// IDLE    | no prefix seen
// E0      | extended prefix seen
// F0      | break prefix seen
// E0F0    | extended break prefix seen
module ps2_kbd_evq #(
  parameter int DEPTH_LOG2  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 50000
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  output logic [7:0]            evt_code,
  output logic                  evt_break,
  output logic                  evt_ext,
  output logic                  evt_shift,
  output logic                  evt_caps,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  parity_err,
  output logic                  frame_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   clk_s, data_s, fall;

  logic [9:0]      sh;
  logic [10:0]     frame_full;
  logic [3:0]      bit_cnt;
  logic [WD_W-1:0] wd;
  logic            frame_bad, par_bad;
  logic            byte_valid;
  logic [7:0]      byte_data;

  state_t state, state_n;
  logic   emit, emit_ext, emit_brk;
  logic   lheld, rheld, caps_held, caps;
  logic   lheld_n, rheld_n, caps_held_n, caps_n;

  logic [11:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [11:0]           head;
  logic                  full, pop, wr_en;

  // Idle PS/2 lines are high, so the synchronisers come out of reset high to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  assign frame_full = {data_s, sh};
  assign frame_bad  = frame_full[0] | ~frame_full[10];
  assign par_bad    = ~(^frame_full[9:1]);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      sh         <= '0;
      bit_cnt    <= '0;
      wd         <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        sh <= frame_full[10:1];
        wd <= WD_W'(TIMEOUT);
        if (bit_cnt == 4'd10) begin
          bit_cnt    <= '0;
          byte_valid <= ~frame_bad & ~par_bad;
          parity_err <= ~frame_bad & par_bad;
          frame_err  <= frame_bad;
          byte_data  <= frame_full[8:1];
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        // Watchdog only runs inside a frame; it was reloaded by the edge that started it.
        if (wd == WD_W'(1)) begin
          bit_cnt   <= '0;
          frame_err <= 1'b1;
        end else begin
          wd <= wd - WD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state     <= ST_IDLE;
      lheld     <= 1'b0;
      rheld     <= 1'b0;
      caps_held <= 1'b0;
      caps      <= 1'b0;
    end else begin
      state     <= state_n;
      lheld     <= lheld_n;
      rheld     <= rheld_n;
      caps_held <= caps_held_n;
      caps      <= caps_n;
    end
  end

  always_comb begin
    state_n     = state;
    emit        = 1'b0;
    emit_ext    = 1'b0;
    emit_brk    = 1'b0;
    lheld_n     = lheld;
    rheld_n     = rheld;
    caps_held_n = caps_held;
    caps_n      = caps;
    if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (byte_data == 8'hE0)      state_n = ST_E0;
          else if (byte_data == 8'hF0) state_n = ST_F0;
          else                         emit = 1'b1;
        end
        ST_E0: begin
          if (byte_data == 8'hF0)      state_n = ST_E0F0;
          else if (byte_data != 8'hE0) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
        ST_F0: begin
          if (byte_data != 8'hF0) begin
            emit     = 1'b1;
            emit_brk = 1'b1;
          end
        end
        ST_E0F0: begin
          emit     = 1'b1;
          emit_ext = 1'b1;
          emit_brk = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end
    if (emit) state_n = ST_IDLE;
    // Extended codes share numbers with modifiers (e.g. E0 12) but are different keys.
    if (emit && !emit_ext) begin
      case (byte_data)
        8'h12: lheld_n = ~emit_brk;
        8'h59: rheld_n = ~emit_brk;
        8'h58: begin
          if (emit_brk) begin
            caps_held_n = 1'b0;
          end else begin
            if (!caps_held) caps_n = ~caps;
            caps_held_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign full  = (count == FULL_CNT);
  assign pop   = evt_valid & evt_ready;
  assign wr_en = emit & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {emit_ext, emit_brk, lheld_n | rheld_n, caps_n, byte_data};
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (emit && full && !pop) overflow <= 1'b1;
    end
  end

  assign evt_valid = (count != '0);
  assign head      = evt_valid ? mem[rd_ptr] : '0;
  assign evt_ext   = head[11];
  assign evt_break = head[10];
  assign evt_shift = head[9];
  assign evt_caps  = head[8];
  assign evt_code  = head[7:0];

endmodule

// File: tb/tb_ps2_kbd_evq.sv
// Directed bench for ps2_kbd_evq: table of single frames plus hand sequences for
// latency, error pulses, watchdog, reset mid-frame and FIFO full/overflow behaviour.
module tb_ps2_kbd_evq;
  localparam int DL2  = 2;
  localparam int TO   = 300;
  localparam int HALF = 10;

  logic         clk = 1'b0;
  logic         clrn, ps2_clk, ps2_data, evt_ready;
  logic [7:0]   evt_code;
  logic         evt_break, evt_ext, evt_shift, evt_caps, evt_valid;
  logic [DL2:0] count;
  logic         overflow, parity_err, frame_err;
  logic [11:0]  head_word;

  int checks   = 0;
  int failures = 0;
  int pe_n, fe_n;

  typedef struct {
    logic [7:0]  code;
    logic        has_evt;
    logic [11:0] word;
  } vec_t;
  vec_t vecs [20];

  ps2_kbd_evq #(.DEPTH_LOG2(DL2), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_code(evt_code), .evt_break(evt_break), .evt_ext(evt_ext),
    .evt_shift(evt_shift), .evt_caps(evt_caps), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .count(count), .overflow(overflow),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  assign head_word = {evt_ext, evt_break, evt_shift, evt_caps, evt_code};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input bit flip_par, input bit flip_stop);
    return {~flip_stop, (~^b) ^ flip_par, b, 1'b0};
  endfunction

  // Leaves ps2_clk low right after the last falling edge so callers can time from it.
  task automatic ps2_bits(input logic [10:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i != nbits - 1) begin
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
      end
    end
  endtask

  task automatic ps2_release();
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    ps2_bits(mkframe(b, 1'b0, 1'b0), 11);
    ps2_release();
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic count_pulses(input int cycles);
    pe_n = 0;
    fe_n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (parity_err) pe_n++;
      if (frame_err)  fe_n++;
    end
  endtask

  initial begin
    vecs[0]  = '{8'hF0, 1'b0, 12'h000};
    vecs[1]  = '{8'h1C, 1'b1, 12'h41C};
    vecs[2]  = '{8'hE0, 1'b0, 12'h000};
    vecs[3]  = '{8'hF0, 1'b0, 12'h000};
    vecs[4]  = '{8'h75, 1'b1, 12'hC75};
    vecs[5]  = '{8'h12, 1'b1, 12'h212};
    vecs[6]  = '{8'h1C, 1'b1, 12'h21C};
    vecs[7]  = '{8'hF0, 1'b0, 12'h000};
    vecs[8]  = '{8'h12, 1'b1, 12'h412};
    vecs[9]  = '{8'h1C, 1'b1, 12'h01C};
    vecs[10] = '{8'h58, 1'b1, 12'h158};
    vecs[11] = '{8'h58, 1'b1, 12'h158};
    vecs[12] = '{8'hF0, 1'b0, 12'h000};
    vecs[13] = '{8'h58, 1'b1, 12'h558};
    vecs[14] = '{8'h58, 1'b1, 12'h058};
    vecs[15] = '{8'hE0, 1'b0, 12'h000};
    vecs[16] = '{8'h12, 1'b1, 12'h812};
    vecs[17] = '{8'h59, 1'b1, 12'h259};
    vecs[18] = '{8'hF0, 1'b0, 12'h000};
    vecs[19] = '{8'h59, 1'b1, 12'h459};

    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_word", 32'(head_word), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_errs", 32'({parity_err, frame_err}), 32'd0);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    // First event with latency: valid appears on the fourth sample after the last falling edge.
    ps2_bits(mkframe(8'h1C, 1'b0, 1'b0), 11);
    repeat (3) @(negedge clk);
    chk("lat_not_yet", 32'(evt_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(evt_valid), 32'd1);
    ps2_release();
    chk("first_word", 32'(head_word), 32'h01C);
    chk("first_count", 32'(count), 32'd1);
    pop_one();
    chk("first_popped", 32'(count), 32'd0);

    for (int v = 0; v < 20; v++) begin
      send(vecs[v].code);
      if (vecs[v].has_evt) begin
        chk($sformatf("vec%0d_valid", v), 32'(evt_valid), 32'd1);
        chk($sformatf("vec%0d_word", v), 32'(head_word), 32'(vecs[v].word));
        chk($sformatf("vec%0d_count", v), 32'(count), 32'd1);
        pop_one();
      end else begin
        chk($sformatf("vec%0d_noevt", v), 32'(evt_valid), 32'd0);
      end
    end

    ps2_bits(mkframe(8'h1C, 1'b1, 1'b0), 11);
    count_pulses(8);
    ps2_release();
    chk("par_pulse", 32'(pe_n), 32'd1);
    chk("par_no_fe", 32'(fe_n), 32'd0);
    chk("par_count", 32'(count), 32'd0);

    ps2_bits(mkframe(8'h1C, 1'b0, 1'b1), 11);
    count_pulses(8);
    ps2_release();
    chk("stop_fe", 32'(fe_n), 32'd1);
    chk("stop_no_pe", 32'(pe_n), 32'd0);
    chk("stop_count", 32'(count), 32'd0);

    ps2_bits(mkframe(8'h2B, 1'b0, 1'b0), 5);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    count_pulses(TO - 20);
    chk("wd_early", 32'(fe_n), 32'd0);
    count_pulses(60);
    chk("wd_fe", 32'(fe_n), 32'd1);
    chk("wd_noevt", 32'(evt_valid), 32'd0);
    send(8'h1C);
    chk("wd_after_word", 32'(head_word), 32'h01C);
    pop_one();

    ps2_bits(mkframe(8'h2B, 1'b0, 1'b0), 5);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    repeat (4) @(negedge clk);
    send(8'h1C);
    chk("rstmid_word", 32'(head_word), 32'h01C);
    chk("rstmid_count", 32'(count), 32'd1);
    pop_one();

    send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
    chk("full_count", 32'(count), 32'd4);
    chk("full_no_ovf", 32'(overflow), 32'd0);
    chk("full_head", 32'(evt_code), 32'h1C);

    // Pop in the same cycle as the write into a full FIFO.
    ps2_bits(mkframe(8'h34, 1'b0, 1'b0), 11);
    repeat (3) @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    ps2_release();
    chk("pp_count", 32'(count), 32'd4);
    chk("pp_no_ovf", 32'(overflow), 32'd0);
    chk("pp_head", 32'(evt_code), 32'h1B);

    send(8'h33);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    chk("pop0", 32'(evt_code), 32'h1B); pop_one();
    chk("pop1", 32'(evt_code), 32'h23); pop_one();
    chk("pop2", 32'(evt_code), 32'h2B); pop_one();
    chk("pop3", 32'(evt_code), 32'h34); pop_one();
    chk("drained_valid", 32'(evt_valid), 32'd0);
    chk("drained_count", 32'(count), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    evt_ready = 1'b0;
    chk("empty_pop_count", 32'(count), 32'd0);
    chk("empty_pop_valid", 32'(evt_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
